// File: rtl/vector_output_sequencer.sv
// Buffers flagged CPU output vectors in a small FIFO and streams them MSB lane first over valid/ready.
// Optional frame-end pulse is compiled in with `define VOSEQ_FRAME_EN.
module vector_output_sequencer #(
  parameter int VECTOR_SIZE   = 6,
  parameter int OUTPUT_WIDTH  = 8,
  parameter int FIFO_DEPTH    = 4,
  parameter int FRAME_VECTORS = 4096
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic [VECTOR_SIZE*OUTPUT_WIDTH-1:0]  inData,
  input  logic                                 inFlag,
  output logic                                 full,
  output logic                                 overflow,
  output logic [$clog2(FIFO_DEPTH):0]          level,
  output logic [OUTPUT_WIDTH-1:0]              byteOut,
  output logic                                 byteValid,
  input  logic                                 byteReady,
  output logic                                 frameDone
);
  localparam int VW = VECTOR_SIZE * OUTPUT_WIDTH;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam int CW = (VECTOR_SIZE > 1) ? $clog2(VECTOR_SIZE) : 1;

  if (FRAME_VECTORS < 1 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_param
    $error("vector_output_sequencer: FIFO_DEPTH must be a power of 2 >= 2 and FRAME_VECTORS >= 1");
  end

  typedef enum logic {IDLE, SEND} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [VW-1:0]   r_mem [FIFO_DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [LW-1:0]   r_level;
  logic [VW-1:0]   r_shift;
  logic [CW-1:0]   r_lane_cnt;
  logic            r_overflow;
  logic            w_push;
  logic            w_pop;
  logic            w_hs;
  logic            w_last;
  logic            w_empty;

  // full/level come from the registered count, so a same-cycle pop never admits an extra push
  assign full    = (r_level == LW'(FIFO_DEPTH));
  assign w_empty = (r_level == '0);
  assign w_push  = inFlag && !full;
  assign w_hs    = (r_state == SEND) && byteReady;
  assign w_last  = (r_lane_cnt == CW'(VECTOR_SIZE - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = SEND;
        end
      end
      SEND: begin
        if (w_hs && w_last) begin
          if (!w_empty) w_pop = 1'b1;
          else          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
      r_lane_cnt <= '0;
      r_shift    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push != w_pop) r_level <= w_push ? r_level + 1'b1 : r_level - 1'b1;
      if (inFlag && full) r_overflow <= 1'b1;
      // Shifting on the final handshake too leaves the register zeroed once the stream drains
      if (w_pop) begin
        r_shift    <= r_mem[r_rd_ptr];
        r_lane_cnt <= '0;
      end else if (w_hs) begin
        r_shift    <= r_shift << OUTPUT_WIDTH;
        r_lane_cnt <= r_lane_cnt + 1'b1;
      end
    end
  end

  // Pop and push never touch the same slot: rd==wr only when empty or full
  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= inData;
  end

  assign byteOut   = r_shift[VW-1 -: OUTPUT_WIDTH];
  assign byteValid = (r_state == SEND);
  assign level     = r_level;
  assign overflow  = r_overflow;

`ifdef VOSEQ_FRAME_EN
  localparam int FW = $clog2(FRAME_VECTORS + 1);

  logic [FW-1:0] r_frame_cnt;
  logic          w_frame_hit;

  // Counter sits at FRAME_VECTORS for exactly one cycle, which is the frameDone pulse
  assign w_frame_hit = (r_frame_cnt == FW'(FRAME_VECTORS));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_frame_cnt <= '0;
    end else if (w_frame_hit) begin
      r_frame_cnt <= (w_hs && w_last) ? FW'(1) : '0;
    end else if (w_hs && w_last) begin
      r_frame_cnt <= r_frame_cnt + 1'b1;
    end
  end

  assign frameDone = w_frame_hit;
`else
  assign frameDone = 1'b0;
`endif

endmodule

// File: tb/tb_vector_output_sequencer.sv
// Directed bench for vector_output_sequencer: single vector, backpressure, overflow, back-to-back, async reset, frame pulse.
module tb_vector_output_sequencer;
  localparam int VS = 6;
  localparam int OW = 8;
  localparam int FD = 4;
`ifdef VOSEQ_FRAME_EN
  localparam int FV = 2;
`else
  localparam int FV = 4096;
`endif
  localparam int LW = $clog2(FD) + 1;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic [VS*OW-1:0] inData = '0;
  logic             inFlag = 1'b0;
  logic             full;
  logic             overflow;
  logic [LW-1:0]    level;
  logic [OW-1:0]    byteOut;
  logic             byteValid;
  logic             byteReady = 1'b0;
  logic             frameDone;

  vector_output_sequencer #(
    .VECTOR_SIZE(VS), .OUTPUT_WIDTH(OW), .FIFO_DEPTH(FD), .FRAME_VECTORS(FV)
  ) dut (
    .clock(clock), .reset(reset), .inData(inData), .inFlag(inFlag),
    .full(full), .overflow(overflow), .level(level),
    .byteOut(byteOut), .byteValid(byteValid), .byteReady(byteReady),
    .frameDone(frameDone)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int fd_total = 0;
  logic [7:0] rx_q[$];
  int         rx_cyc[$];
  int         fd_cyc[$];

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (reset && byteValid && byteReady) begin
      rx_q.push_back(byteOut);
      rx_cyc.push_back(cyc);
    end
    if (frameDone) begin
      fd_cyc.push_back(cyc);
      fd_total++;
    end
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [VS*OW-1:0] v);
    inFlag = 1'b1;
    inData = v;
    step();
    inFlag = 1'b0;
  endtask

  task automatic clear_rx();
    rx_q.delete();
    rx_cyc.delete();
    fd_cyc.delete();
  endtask

  task automatic wait_rx(input int n, input string tag);
    int t = 0;
    while (rx_q.size() < n && t < 300) begin
      step();
      t++;
    end
    check_val({tag, "_cnt"}, rx_q.size(), n);
  endtask

  task automatic check_vec(input int idx, input logic [VS*OW-1:0] v, input string tag);
    for (int k = 0; k < VS; k++) begin
      logic [7:0] got;
      int         pos;
      pos = idx * VS + k;
      got = (pos < rx_q.size()) ? rx_q[pos] : 8'hxx;
      check_val($sformatf("%s_v%0d_b%0d", tag, idx, k), got, v[VS*OW-1-OW*k -: OW]);
    end
  endtask

  task automatic do_reset();
    inFlag = 1'b0;
    reset  = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [VS*OW-1:0] ov[6];
    logic [VS*OW-1:0] bb[3];
    int gaps;
    int base;

    // Reset values
    step();
    step();
    check_val("rst_full", full, 0);
    check_val("rst_overflow", overflow, 0);
    check_val("rst_level", level, 0);
    check_val("rst_byteOut", byteOut, 0);
    check_val("rst_byteValid", byteValid, 0);
    check_val("rst_frameDone", frameDone, 0);
    reset = 1'b1;
    step();

    // Single vector, consumer always ready
    clear_rx();
    byteReady = 1'b1;
    push(48'h0102_0304_0506);
    check_val("basic_lat_valid", byteValid, 0);
    check_val("basic_lat_level", level, 1);
    step();
    check_val("basic_first_valid", byteValid, 1);
    check_val("basic_first_byte", byteOut, 8'h01);
    check_val("basic_pop_level", level, 0);
    wait_rx(6, "basic");
    check_vec(0, 48'h0102_0304_0506, "basic");
    check_val("basic_span", (rx_cyc.size() == 6) ? rx_cyc[5] - rx_cyc[0] : -1, 5);
    check_val("basic_done_valid", byteValid, 0);

    // Backpressure mid-vector
    clear_rx();
    push(48'hA1A2_A3A4_A5A6);
    step();
    step();
    step();
    byteReady = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check_val($sformatf("bp_hold_valid%0d", i), byteValid, 1);
      check_val($sformatf("bp_hold_byte%0d", i), byteOut, 8'hA3);
    end
    byteReady = 1'b1;
    wait_rx(6, "bp");
    check_vec(0, 48'hA1A2_A3A4_A5A6, "bp");
    for (int i = 0; i < 4; i++) step();
    check_val("bp_no_dup", rx_q.size(), 6);

    // Overflow: shift register plus four FIFO slots absorb five vectors, the sixth is dropped
    clear_rx();
    byteReady = 1'b0;
    ov[0] = 48'h1112_1314_1516;
    ov[1] = 48'h2122_2324_2526;
    ov[2] = 48'h3132_3334_3536;
    ov[3] = 48'h4142_4344_4546;
    ov[4] = 48'h5152_5354_5556;
    ov[5] = 48'hF1F2_F3F4_F5F6;
    for (int i = 0; i < 5; i++) push(ov[i]);
    check_val("ovf_level4", level, 4);
    check_val("ovf_full", full, 1);
    check_val("ovf_not_yet", overflow, 0);
    check_val("ovf_head_held", byteOut, 8'h11);
    push(ov[5]);
    check_val("ovf_sticky", overflow, 1);
    check_val("ovf_level_after_drop", level, 4);
    byteReady = 1'b1;
    wait_rx(30, "ovf");
    for (int i = 0; i < 5; i++) check_vec(i, ov[i], "ovf");
    for (int i = 0; i < 10; i++) step();
    check_val("ovf_no_dropped_bytes", rx_q.size(), 30);
    check_val("ovf_idle_valid", byteValid, 0);
    check_val("ovf_drained_level", level, 0);
    check_val("ovf_drained_full", full, 0);
    check_val("ovf_still_sticky", overflow, 1);

    // Back-to-back vectors, no gaps expected
    do_reset();
    check_val("b2b_ovf_cleared", overflow, 0);
    clear_rx();
    byteReady = 1'b1;
    bb[0] = 48'h6162_6364_6566;
    bb[1] = 48'h7172_7374_7576;
    bb[2] = 48'h8182_8384_8586;
    for (int i = 0; i < 3; i++) push(bb[i]);
    wait_rx(18, "b2b");
    for (int i = 0; i < 3; i++) check_vec(i, bb[i], "b2b");
    gaps = 0;
    for (int i = 1; i < rx_cyc.size(); i++) if (rx_cyc[i] != rx_cyc[i-1] + 1) gaps++;
    check_val("b2b_gaps", gaps, 0);
    step();
    check_val("b2b_idle_valid", byteValid, 0);
    check_val("b2b_level", level, 0);

    // Asynchronous reset during the third byte
    clear_rx();
    push(48'hC1C2_C3C4_C5C6);
    push(48'hD1D2_D3D4_D5D6);
    step();
    step();
    check_val("rstmid_byte3", byteOut, 8'hC3);
    #2;
    reset = 1'b0;
    #1;
    check_val("rstmid_valid", byteValid, 0);
    check_val("rstmid_level", level, 0);
    check_val("rstmid_byteOut", byteOut, 0);
    check_val("rstmid_full", full, 0);
    step();
    step();
    reset = 1'b1;
    for (int i = 0; i < 10; i++) step();
    check_val("rstmid_no_stale", rx_q.size(), 2);
    push(48'hE1E2_E3E4_E5E6);
    wait_rx(8, "rstmid_after");
    base = 0;
    for (int k = 0; k < VS; k++) begin
      logic [7:0] got;
      got = (2 + k < rx_q.size()) ? rx_q[2 + k] : 8'hxx;
      check_val($sformatf("rstmid_new_b%0d", k), got, 8'hE1 + 8'(k));
      base++;
    end

`ifdef VOSEQ_FRAME_EN
    // Frame pulses after every second vector
    do_reset();
    clear_rx();
    byteReady = 1'b1;
    push(48'h0001_0203_0405);
    push(48'h1011_1213_1415);
    push(48'h2021_2223_2425);
    push(48'h3031_3233_3435);
    wait_rx(24, "frame");
    for (int i = 0; i < 4; i++) step();
    check_val("frame_pulses", fd_cyc.size(), 2);
    check_val("frame_pulse1", (fd_cyc.size() > 0 && rx_cyc.size() > 11) ? fd_cyc[0] - rx_cyc[11] : -1, 1);
    check_val("frame_pulse2", (fd_cyc.size() > 1 && rx_cyc.size() > 23) ? fd_cyc[1] - rx_cyc[23] : -1, 1);
`else
    check_val("frame_none", fd_total, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
